// File: rtl/dht_frame_decoder.sv
// DHT11/DHT22 40-bit frame decoder: checksum, unit conversion, ready/valid hold, error/stale tracking.
// Optional range check on decoded values is enabled by defining DHT_RANGE_CHECK_EN.
module dht_frame_decoder #(
   parameter int unsigned SENSOR_TYPE  = 1,
   parameter int unsigned STALE_CYCLES = 29'd300000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_valid,
   input  logic [39:0] frame_data,
   input  logic        frame_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] humidity,
   output logic [15:0] temperature,
   output logic        stale,
   output logic [7:0]  err_count,
   output logic [15:0] frame_count
);

   localparam int SW = $clog2(STALE_CYCLES + 1);
   localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

   typedef enum logic [1:0] {IDLE, CHECK, CONVERT, HOLD} state_t;

   state_t        state_q, state_d;
   logic [39:0]   frame_q, frame_d;
   logic [15:0]   hum_q, hum_d, temp_q, temp_d;
   logic [7:0]    err_q, err_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic [SW-1:0] stale_q, stale_d;

   logic [7:0]    csum;
   logic [15:0]   hum_dec, temp_dec, mag;
   logic          range_ok, err_inc, enter_hold;

   always_comb begin
      csum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
      mag  = {1'b0, frame_q[22:16], frame_q[15:8]};
      if (SENSOR_TYPE == 0) begin
         // DHT11 reports whole units only; scale to tenths
         hum_dec  = 16'(frame_q[39:32]) * 16'd10;
         temp_dec = 16'(frame_q[23:16]) * 16'd10;
      end else begin
         hum_dec  = frame_q[39:24];
         temp_dec = frame_q[23] ? (16'd0 - mag) : mag;
      end
`ifdef DHT_RANGE_CHECK_EN
      range_ok = (hum_dec <= 16'd1000) &&
                 ($signed(temp_dec) >= -16'sd400) &&
                 ($signed(temp_dec) <= 16'sd800);
`else
      range_ok = 1'b1;
`endif
   end

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      hum_d      = hum_q;
      temp_d     = temp_q;
      fcnt_d     = fcnt_q;
      enter_hold = 1'b0;
      // all error sources collapse into a single increment per cycle
      err_inc    = frame_err || (frame_valid && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (frame_valid) begin
               frame_d = frame_data;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (csum != frame_q[7:0]) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            if (range_ok) begin
               hum_d      = hum_dec;
               temp_d     = temp_dec;
               enter_hold = 1'b1;
               state_d    = HOLD;
            end else begin
               err_inc = 1'b1;
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (out_ready) begin
               fcnt_d  = fcnt_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
      if (enter_hold)
         stale_d = '0;
      else if (stale_q != STALE_MAX)
         stale_d = stale_q + 1'b1;
      else
         stale_d = stale_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         frame_q <= '0;
         hum_q   <= '0;
         temp_q  <= '0;
         err_q   <= '0;
         fcnt_q  <= '0;
         stale_q <= STALE_MAX;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         hum_q   <= hum_d;
         temp_q  <= temp_d;
         err_q   <= err_d;
         fcnt_q  <= fcnt_d;
         stale_q <= stale_d;
      end
   end

   assign out_valid   = (state_q == HOLD);
   assign humidity    = hum_q;
   assign temperature = temp_q;
   assign stale       = (stale_q == STALE_MAX);
   assign err_count   = err_q;
   assign frame_count = fcnt_q;

endmodule

// File: tb/tb_dht_frame_decoder.sv
// Scoreboard bench for dht_frame_decoder: one DHT22 and one DHT11 instance, STALE_CYCLES=100.
module tb_dht_frame_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, fv, fe, rdy, sel;
   logic [39:0] fd;

   wire         fv22 = fv & sel, fe22 = fe & sel;
   wire         fv11 = fv & ~sel, fe11 = fe & ~sel;
   logic        ov22, ov11, st22, st11;
   logic [15:0] h22, h11, t22, t11, fc22, fc11;
   logic [7:0]  ec22, ec11;

   wire         ov = sel ? ov22 : ov11;
   wire         st = sel ? st22 : st11;
   wire [15:0]  h  = sel ? h22  : h11;
   wire [15:0]  t  = sel ? t22  : t11;
   wire [15:0]  fc = sel ? fc22 : fc11;
   wire [7:0]   ec = sel ? ec22 : ec11;

   dht_frame_decoder #(.SENSOR_TYPE(1), .STALE_CYCLES(100)) dut22 (
      .clk(clk), .rst(rst), .frame_valid(fv22), .frame_data(fd), .frame_err(fe22),
      .out_valid(ov22), .out_ready(rdy), .humidity(h22), .temperature(t22),
      .stale(st22), .err_count(ec22), .frame_count(fc22));

   dht_frame_decoder #(.SENSOR_TYPE(0), .STALE_CYCLES(100)) dut11 (
      .clk(clk), .rst(rst), .frame_valid(fv11), .frame_data(fd), .frame_err(fe11),
      .out_valid(ov11), .out_ready(rdy), .humidity(h11), .temperature(t11),
      .stale(st11), .err_count(ec11), .frame_count(fc11));

   typedef struct packed {logic [15:0] hum; logic [15:0] temp;} exp_t;
   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [39:0] d);
      fd = d;
      fv = 1'b1;
      step();
      fv = 1'b0;
   endtask

   // cyc counts edges from the latching edge; -1 on timeout
   task automatic wait_valid(input int maxc, output int cyc);
      cyc = 1;
      while (!ov && cyc < maxc) begin
         step();
         cyc++;
      end
      if (!ov) cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_valid sel=%0d got %0b want 0", s, ov); end
         tests++; if (h !== 16'd0 || t !== 16'd0) begin fails++; $display("FAIL reset_data sel=%0d got %h/%h want 0/0", s, h, t); end
         tests++; if (st !== 1'b1) begin fails++; $display("FAIL reset_stale sel=%0d got %0b want 1", s, st); end
         tests++; if (ec !== 8'd0 || fc !== 16'd0) begin fails++; $display("FAIL reset_counts sel=%0d got %0d/%0d want 0/0", s, ec, fc); end
      end
      sel = 1'b1;
   endtask

   task automatic test_dht22_basic();
      int cyc;
      exp_t e;
      sel = 1'b1; rdy = 1'b1; #1;
      sb.push_back('{16'd652, 16'd351});
      send(40'h028C015FEE);
      wait_valid(8, cyc);
      tests++; if (cyc !== 3) begin fails++; $display("FAIL basic_latency got %0d want 3", cyc); end
      e = sb.pop_front();
      tests++; if (h !== e.hum || t !== e.temp) begin fails++; $display("FAIL basic_data got %0d/%0d want %0d/%0d", h, t, e.hum, e.temp); end
      step();
      tests++; if (fc !== 16'd1 || st !== 1'b0 || ov !== 1'b0) begin fails++; $display("FAIL basic_after got fc=%0d st=%0b ov=%0b want 1/0/0", fc, st, ov); end
   endtask

   task automatic test_neg_temp();
      int cyc;
      exp_t e;
      sb.push_back('{16'd652, 16'hFF9B});
      send(40'h028C806573);
      wait_valid(8, cyc);
      tests++; if (cyc !== 3) begin fails++; $display("FAIL neg_latency got %0d want 3", cyc); end
      e = sb.pop_front();
      tests++; if (h !== e.hum || t !== e.temp) begin fails++; $display("FAIL neg_data got %h/%h want %h/%h", h, t, e.hum, e.temp); end
      step();
      tests++; if (fc !== 16'd2) begin fails++; $display("FAIL neg_count got %0d want 2", fc); end
   endtask

   task automatic test_checksum_err();
      logic seen;
      seen = 1'b0;
      send(40'h028C015F00);
      repeat (6) begin if (ov) seen = 1'b1; step(); end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL csum_novalid got 1 want 0"); end
      tests++; if (ec !== 8'd1) begin fails++; $display("FAIL csum_err got %0d want 1", ec); end
      tests++; if (h !== 16'd652 || t !== 16'hFF9B) begin fails++; $display("FAIL csum_hold got %h/%h want 028c/ff9b", h, t); end
      fe = 1'b1;
      repeat (300) step();
      fe = 1'b0;
      tests++; if (ec !== 8'd255) begin fails++; $display("FAIL err_saturate got %0d want 255", ec); end
   endtask

   task automatic test_reset_mid_check();
      logic seen;
      seen = 1'b0;
      send(40'h028C015FEE);
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++; if (ov !== 1'b0 || st !== 1'b1) begin fails++; $display("FAIL midrst_flags got ov=%0b st=%0b want 0/1", ov, st); end
      tests++; if (ec !== 8'd0 || fc !== 16'd0 || h !== 16'd0) begin fails++; $display("FAIL midrst_counts got %0d/%0d/%0d want 0/0/0", ec, fc, h); end
      // frame coincident with reset must be ignored too
      fd = 40'h028C015FEE; fv = 1'b1; rst = 1'b1;
      step();
      fv = 1'b0; rst = 1'b0;
      repeat (6) begin if (ov) seen = 1'b1; step(); end
      tests++; if (seen !== 1'b0 || fc !== 16'd0) begin fails++; $display("FAIL midrst_discard got ov=%0b fc=%0d want 0/0", seen, fc); end
   endtask

   task automatic test_range();
`ifdef DHT_RANGE_CHECK_EN
      logic seen;
      seen = 1'b0;
      send(40'h03E900C8B4);
      repeat (6) begin if (ov) seen = 1'b1; step(); end
      tests++; if (seen !== 1'b0 || ec !== 8'd1) begin fails++; $display("FAIL range_reject got ov=%0b ec=%0d want 0/1", seen, ec); end
      tests++; if (h !== 16'd0 || t !== 16'd0) begin fails++; $display("FAIL range_hold got %0d/%0d want 0/0", h, t); end
`else
      int cyc;
      exp_t e;
      sb.push_back('{16'd1001, 16'd200});
      send(40'h03E900C8B4);
      wait_valid(8, cyc);
      tests++; if (cyc !== 3) begin fails++; $display("FAIL range_latency got %0d want 3", cyc); end
      e = sb.pop_front();
      tests++; if (h !== e.hum || t !== e.temp) begin fails++; $display("FAIL range_data got %0d/%0d want %0d/%0d", h, t, e.hum, e.temp); end
      step();
`endif
   endtask

   task automatic test_stale();
      int cyc;
      exp_t e;
      rdy = 1'b1;
      sb.push_back('{16'd652, 16'd351});
      send(40'h028C015FEE);
      wait_valid(8, cyc);
      tests++; if (cyc !== 3) begin fails++; $display("FAIL stale_latency got %0d want 3", cyc); end
      e = sb.pop_front();
      tests++; if (h !== e.hum || t !== e.temp) begin fails++; $display("FAIL stale_data got %0d/%0d want %0d/%0d", h, t, e.hum, e.temp); end
      repeat (99) step();
      tests++; if (st !== 1'b0) begin fails++; $display("FAIL stale_early got %0b want 0", st); end
      step();
      tests++; if (st !== 1'b1) begin fails++; $display("FAIL stale_rise got %0b want 1", st); end
   endtask

   task automatic test_dht11_hold();
      int cyc;
      exp_t e;
      logic stable;
      sel = 1'b0; rdy = 1'b0; #1;
      stable = 1'b1;
      sb.push_back('{16'd550, 16'd240});
      send(40'h370018004F);
      wait_valid(8, cyc);
      tests++; if (cyc !== 3) begin fails++; $display("FAIL d11_latency got %0d want 3", cyc); end
      e = sb.pop_front();
      for (int i = 0; i < 10; i++) begin
         if (!ov || h !== e.hum || t !== e.temp) stable = 1'b0;
         if (i == 4) send(40'h370018004F);
         else step();
      end
      tests++; if (stable !== 1'b1) begin fails++; $display("FAIL d11_stable got 0 want 1"); end
      tests++; if (h !== e.hum || t !== e.temp) begin fails++; $display("FAIL d11_data got %0d/%0d want %0d/%0d", h, t, e.hum, e.temp); end
      tests++; if (ec !== 8'd1) begin fails++; $display("FAIL d11_drop_err got %0d want 1", ec); end
      rdy = 1'b1;
      step();
      tests++; if (fc !== 16'd1 || ov !== 1'b0) begin fails++; $display("FAIL d11_accept got fc=%0d ov=%0b want 1/0", fc, ov); end
      sel = 1'b1; #1;
   endtask

   task automatic test_back_to_back();
      logic [39:0] tf [6];
      logic [15:0] th [6];
      logic [15:0] tt [6];
      logic [15:0] fc0;
      int cyc;
      exp_t e;
      tf[0] = 40'h028C015FEE; th[0] = 16'd652;  tt[0] = 16'd351;
      tf[1] = 40'h028C806573; th[1] = 16'd652;  tt[1] = 16'hFF9B;
      tf[2] = 40'h01F400FAEF; th[2] = 16'd500;  tt[2] = 16'd250;
      tf[3] = 40'h0000819011; th[3] = 16'd0;    tt[3] = 16'hFE70;
      tf[4] = 40'h0000032023; th[4] = 16'd0;    tt[4] = 16'd800;
      tf[5] = 40'h03E80000EB; th[5] = 16'd1000; tt[5] = 16'd0;
      sel = 1'b1; rdy = 1'b1; #1;
      fc0 = fc;
      for (int i = 0; i < 6; i++) begin
         sb.push_back('{th[i], tt[i]});
         send(tf[i]);
         wait_valid(8, cyc);
         tests++; if (cyc !== 3) begin fails++; $display("FAIL b2b_latency[%0d] got %0d want 3", i, cyc); end
         e = sb.pop_front();
         tests++; if (h !== e.hum || t !== e.temp) begin fails++; $display("FAIL b2b_data[%0d] got %h/%h want %h/%h", i, h, t, e.hum, e.temp); end
         step();
      end
      tests++; if (fc !== fc0 + 16'd6 || sb.size() != 0) begin fails++; $display("FAIL b2b_count got %0d want %0d", fc, fc0 + 16'd6); end
   endtask

   initial begin
      rst = 1'b1; fv = 1'b0; fe = 1'b0; rdy = 1'b0; sel = 1'b1; fd = '0;
      @(negedge clk);
      test_reset();
      test_dht22_basic();
      test_neg_temp();
      test_checksum_err();
      test_reset_mid_check();
      test_range();
      test_stale();
      test_dht11_hold();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
